// File: rtl/switch_arbiter.sv
// Central output arbiter: one round-robin arbiter per output port, a registered one-cycle grant,
// mux select/valid aligned to the FIFO read latency, and per-output grant counters.
module switch_arbiter #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            port_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] pkt_dst,
    input  logic [NUM_PORTS-1:0]            out_en,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [NUM_PORTS*SEL_W-1:0]      out_sel,
    output logic [NUM_PORTS-1:0]            out_valid,
    output logic [NUM_PORTS-1:0]            dst_err,
    output logic [NUM_PORTS*CNT_W-1:0]      grant_cnt
);

    logic [NUM_PORTS-1:0]                        tgt_vld;
    logic [NUM_PORTS-1:0][SEL_W-1:0]             tgt;
    logic [NUM_PORTS-1:0]                        eff_req;
    logic [NUM_PORTS-1:0]                        win_vld;
    logic [NUM_PORTS-1:0][SEL_W-1:0]             win_idx;
    logic [NUM_PORTS-1:0]                        grant_d;

    logic [NUM_PORTS-1:0]                        grant_q;
    logic [NUM_PORTS-1:0]                        dst_err_q;
    logic [NUM_PORTS-1:0][SEL_W-1:0]             rr_ptr_q;
    logic [NUM_PORTS-1:0][CNT_W-1:0]             cnt_q;
    logic [NUM_PORTS-1:0]                        gvld_q;
    logic [NUM_PORTS-1:0][SEL_W-1:0]             gsel_q;

    logic [RD_LATENCY-1:0][NUM_PORTS-1:0]            pipe_vld_q;
    logic [RD_LATENCY-1:0][NUM_PORTS-1:0][SEL_W-1:0] pipe_sel_q;
    logic [RD_LATENCY-1:0][NUM_PORTS-1:0]            vld_chain;
    logic [RD_LATENCY-1:0][NUM_PORTS-1:0][SEL_W-1:0] sel_chain;

    // Target output is the lowest set destination bit; bits above NUM_PORTS-1 are ignored.
    always_comb begin
        tgt_vld = '0;
        tgt     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = NUM_PORTS - 1; j >= 0; j--) begin
                if (pkt_dst[i*ADDR_WIDTH + j]) begin
                    tgt_vld[i] = 1'b1;
                    tgt[i]     = SEL_W'(j);
                end
            end
        end
    end

    // A port is masked while its grant is high because its request has not dropped yet.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        eff_req = port_req & ~grant_q;
        win_vld = '0;
        win_idx = '0;
        grant_d = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (out_en[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = (int'(rr_ptr_q[o]) + k) % NUM_PORTS;
                    if (!win_vld[o] && eff_req[idx] && tgt_vld[idx] && (tgt[idx] == SEL_W'(o)))
                    begin
                        win_vld[o] = 1'b1;
                        win_idx[o] = SEL_W'(idx);
                    end
                end
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (win_vld[o] && (win_idx[o] == SEL_W'(i))) begin
                    grant_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= '0;
            dst_err_q <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            gvld_q    <= '0;
            gsel_q    <= '0;
        end else begin
            grant_q   <= grant_d;
            dst_err_q <= port_req & ~tgt_vld;
            gvld_q    <= win_vld;
            gsel_q    <= win_idx;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (win_vld[o]) begin
                    rr_ptr_q[o] <= SEL_W'((int'(win_idx[o]) + 1) % NUM_PORTS);
                    cnt_q[o]    <= cnt_q[o] + CNT_W'(1);
                end
            end
        end
    end

    // Stage 0 is fed from the grant-aligned registers; each later stage from its predecessor.
    always_comb begin
        vld_chain = '0;
        sel_chain = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            if (k == 0) begin
                vld_chain[k] = gvld_q;
                sel_chain[k] = gsel_q;
            end else begin
                vld_chain[k] = pipe_vld_q[k-1];
                sel_chain[k] = pipe_sel_q[k-1];
            end
        end
    end

    // Selects load only alongside a valid so out_sel holds its last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            pipe_sel_q <= '0;
        end else begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_vld_q[k] <= vld_chain[k];
                for (int o = 0; o < NUM_PORTS; o++) begin
                    if (vld_chain[k][o]) begin
                        pipe_sel_q[k][o] <= sel_chain[k][o];
                    end
                end
            end
        end
    end

    assign grant     = grant_q;
    assign dst_err   = dst_err_q;
    assign grant_cnt = cnt_q;
    assign out_valid = pipe_vld_q[RD_LATENCY-1];
    assign out_sel   = pipe_sel_q[RD_LATENCY-1];

endmodule

// File: doc/switch_arbiter.md
Name: switch_arbiter

Overview:
- Central output arbiter for the 4-port switch; sits between the NUM_PORTS switch_port instances and the per-output 4:1 data muxes.
- Collects each port's port_req and pkt_dst. Runs an independent round-robin arbiter per output port. Issues a registered one-cycle grant back to the winning port.
- Drives each output mux's select and valid, aligned to the FIFO read latency.
- Keeps a per-output grant counter for debug and verification.

Parameters:
- NUM_PORTS, 4, number of switch ports (inputs = outputs).
- ADDR_WIDTH, 4, width of each pkt_dst field. Destination is one-hot: bit o means output o. Must be >= NUM_PORTS.
- SEL_W, 2, width of a mux select, equal to clog2(NUM_PORTS).
- RD_LATENCY, 1, cycles from a FIFO rd_en (grant) to fifo_data_out valid. Legal range 1..3.
- CNT_W, 16, width of each per-output grant counter.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- port_req, input, NUM_PORTS, bit i = port i is in ARB_WAIT with a valid head packet.
- pkt_dst, input, NUM_PORTS*ADDR_WIDTH, slice i = head-packet target of port i.
- out_en, input, NUM_PORTS, bit o = output o may be granted. Static config.
- grant, output, NUM_PORTS, bit i = one-cycle grant to port i. This is the port's FIFO pop.
- out_sel, output, NUM_PORTS*SEL_W, slice o = input index steering mux o.
- out_valid, output, NUM_PORTS, bit o = mux o carries a packet this cycle.
- dst_err, output, NUM_PORTS, bit i = port i requesting with an all-zero pkt_dst. Registered.
- grant_cnt, output, NUM_PORTS*CNT_W, slice o = total grants issued for output o.

Behaviour:
- Reset (async, rst_n low): grant=0, out_valid=0, out_sel=0, dst_err=0, grant_cnt=0, all rr_ptr=0, latency pipeline flushed. Takes effect immediately, including mid-transfer. Any pending grant/valid is discarded.
- Destination decode: target output of port i = lowest set bit of pkt_dst slice i within [NUM_PORTS-1:0]. Bits above NUM_PORTS-1 are ignored. If no bit is set, the request is never granted and dst_err[i]=1 next cycle for as long as the request persists.
- Effective request: eff_req[i] = port_req[i] & ~grant[i]. Port i is masked in the cycle its grant is high, because its port_req is still high that cycle; this prevents a double grant.
- Per-output arbitration, each cycle, for each output o with out_en[o]=1:
  - Candidates are inputs i with eff_req[i] and target(i)==o.
  - Search starts at rr_ptr[o] and wraps modulo NUM_PORTS. The first candidate found wins.
- Grant timing:
  - grant[winner] is registered: asserted the cycle after the request is sampled, high for exactly one cycle.
  - On the grant edge, rr_ptr[o] <= (winner+1) mod NUM_PORTS.
  - rr_ptr[o] is unchanged when output o has no winner.
- At most one grant per output per cycle. Each port targets one output, so at most one grant per port.
- Different outputs grant in parallel. Back-to-back grants on one output are allowed every cycle, one per distinct input.
- out_en[o]=0: no grants for output o; requests hold; rr_ptr[o] frozen. Deasserting out_en does not cancel grants or valids already issued.
- Mux pipeline: when grant[i] is issued for output o at cycle T, out_valid[o]=1 and out_sel[o]=i at cycle T+RD_LATENCY, for one cycle. out_sel holds its last value while out_valid=0.
- Counter: grant_cnt[o] increments on each grant for output o and wraps at 2^CNT_W.
- port_req dropping without a grant (not expected from switch_port) simply removes the candidate. No error is raised.
- Latency: req rising at edge T, grant at T+1, out_valid at T+1+RD_LATENCY.

Test Plan:
- Single request: reset, port_req=4'b0001, pkt_dst[0]=4'b0100 → grant=4'b0001 for one cycle the cycle after req; out_valid[2]=1 with out_sel[2]=0 exactly RD_LATENCY=1 cycle later; grant_cnt[2]=1; rr_ptr[2]=1.
- Contention round-robin: ports 0,1,2,3 all target output 1, each holding req until granted and then dropping it → grants in order 0,1,2,3 on four consecutive cycles, no double grant; out_sel[1] sequence 0,1,2,3; grant_cnt[1]=4.
- Parallel outputs: port0→out3, port1→out2, port2→out1, port3→out0 simultaneously → grant=4'b1111 in the same cycle; out_valid=4'b1111 one cycle later with out_sel = {0,1,2,3} for out3..out0.
- Fairness after wrap: set rr_ptr[0]=3 via prior grant to port 2 on out0; then ports 0 and 3 request out0 → port 3 granted first, then port 0.
- Error/config: pkt_dst[1]=4'b0000 with port_req[1]=1 → no grant, dst_err[1]=1 while held. out_en[2]=0 with port0→out2 → no grant; raising out_en[2] yields a grant next cycle.
- Reset mid-operation: assert rst_n low the cycle after a grant, before out_valid → out_valid, grant and grant_cnt all 0 immediately; no stale valid after release.
